// File: rtl/led_frame_if.sv
// led_frame_if: frame handshake between the animation source and the
// LED shifter.
//   frame        - WIDTH-bit frame, driven by the source
//   frame_valid  - source presents a frame this cycle
//   frame_ready  - shifter can take a frame (its pending buffer is empty)
// Modports: master = frame source, slave = shifter.
interface led_frame_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] frame;
  logic             frame_valid;
  logic             frame_ready;

  modport master (output frame, output frame_valid, input  frame_ready);
  modport slave  (input  frame, input  frame_valid, output frame_ready);
endinterface

// File: rtl/led_frame_shifter.sv
// led_frame_shifter: takes LED frames over a valid/ready handshake into a
// one-deep pending buffer. Each frame is shifted out MSB-first to a
// 74HC595-style chain and then committed to the LEDs with a latch pulse.
//
// Ports:
//   clk      - system clock; all logic runs on its rising edge
//   rst      - asynchronous, active-high reset; drops any in-flight or
//              pending frame without issuing a latch
//   fin      - led_frame_if.slave (frame, frame_valid, frame_ready)
//   sr_clk   - serial shift clock; each half-period lasts CLK_DIV clk cycles
//   sr_data  - serial data; stable for the whole sr_clk high phase
//   sr_latch - storage-register latch, high for CLK_DIV cycles
//   busy     - a transfer is running or a frame is pending
//
// Optional feature macro: LED_SHIFT_DEDUP_EN. When it is defined, a pending
// frame equal to the last frame sent is dropped in IDLE without being
// transferred.
module led_frame_shifter #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic      clk,
  input  logic      rst,
  led_frame_if.slave fin,
  output logic      sr_clk,
  output logic      sr_data,
  output logic      sr_latch,
  output logic      busy
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t           state;
  logic [WIDTH-1:0] pending;
  logic             pending_full;
  logic [WIDTH-1:0] shreg;
  logic [DW-1:0]    divcnt;
  logic [BW-1:0]    bitcnt;
`ifdef LED_SHIFT_DEDUP_EN
  logic [WIDTH-1:0] last_frame;
`endif

  logic accept;
  logic div_done;

  // The pending buffer cannot be filled and emptied in the same cycle:
  // accept needs pending_full=0, and a load needs pending_full=1.
  assign accept   = fin.frame_valid && !pending_full;
  assign div_done = (divcnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pending      <= '0;
      pending_full <= 1'b0;
      shreg        <= '0;
      divcnt       <= '0;
      bitcnt       <= '0;
`ifdef LED_SHIFT_DEDUP_EN
      last_frame   <= '0;
`endif
    end else begin
      if (accept) begin
        pending      <= fin.frame;
        pending_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (pending_full) begin
            pending_full <= 1'b0;
`ifdef LED_SHIFT_DEDUP_EN
            // A repeat of the frame already on the LEDs is consumed here and
            // never transferred.
            if (pending != last_frame) begin
              shreg      <= pending;
              last_frame <= pending;
              bitcnt     <= '0;
              divcnt     <= '0;
              state      <= SHIFT_LO;
            end
`else
            shreg  <= pending;
            bitcnt <= '0;
            divcnt <= '0;
            state  <= SHIFT_LO;
`endif
          end
        end

        SHIFT_LO: begin
          if (div_done) begin
            divcnt <= '0;
            state  <= SHIFT_HI;
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end

        SHIFT_HI: begin
          if (div_done) begin
            divcnt <= '0;
            // Shift only at the end of the high phase so that sr_data holds
            // through the whole high phase.
            shreg  <= shreg << 1;
            if (bitcnt == BIT_LAST) begin
              bitcnt <= '0;
              state  <= LATCH;
            end else begin
              bitcnt <= bitcnt + 1'b1;
              state  <= SHIFT_LO;
            end
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end

        LATCH: begin
          if (div_done) begin
            divcnt <= '0;
            state  <= IDLE;
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state only. Reset therefore clears
  // them as soon as it is asserted.
  assign sr_clk          = (state == SHIFT_HI);
  assign sr_data         = ((state == SHIFT_LO) || (state == SHIFT_HI)) && shreg[WIDTH-1];
  assign sr_latch        = (state == LATCH);
  assign busy            = (state != IDLE) || pending_full;
  assign fin.frame_ready = !pending_full;

endmodule

// File: tb/tb_led_frame_shifter.sv
module tb_led_frame_shifter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: CLK_DIV=2. DUT B: CLK_DIV=1.
  led_frame_if #(.WIDTH(16)) if_a ();
  led_frame_if #(.WIDTH(16)) if_b ();
  logic a_sclk, a_sdata, a_latch, a_busy;
  logic b_sclk, b_sdata, b_latch, b_busy;

  led_frame_shifter #(.WIDTH(16), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .fin(if_a),
    .sr_clk(a_sclk), .sr_data(a_sdata), .sr_latch(a_latch), .busy(a_busy));

  led_frame_shifter #(.WIDTH(16), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .fin(if_b),
    .sr_clk(b_sclk), .sr_data(b_sdata), .sr_latch(b_latch), .busy(b_busy));

`ifdef LED_SHIFT_DEDUP_EN
  localparam int DEDUP_XFERS = 2;
`else
  localparam int DEDUP_XFERS = 3;
`endif

  // DUT A monitor: captures the bits at each sr_clk rise, then logs one
  // record per latch pulse.
  logic        a_pclk = 1'b0, a_plat = 1'b0;
  logic [15:0] a_acc = '0;
  int          a_rises = 0, a_llen = 0, a_lstart = 0, tot_rises = 0, n_lat = 0;
  logic [15:0] lat_word  [16];
  int          lat_rises [16];
  int          lat_len   [16];
  int          lat_start [16];

  always @(negedge clk) begin
    if (rst) begin
      a_acc <= '0; a_rises <= 0; a_llen <= 0;
    end else begin
      if (a_sclk && !a_pclk) begin
        a_acc     <= {a_acc[14:0], a_sdata};
        a_rises   <= a_rises + 1;
        tot_rises <= tot_rises + 1;
      end
      if (a_latch) begin
        if (!a_plat) a_lstart <= cyc;
        a_llen <= a_llen + 1;
      end else if (a_plat && n_lat < 16) begin
        lat_word[n_lat]  <= a_acc;
        lat_rises[n_lat] <= a_rises;
        lat_len[n_lat]   <= a_llen;
        lat_start[n_lat] <= a_lstart;
        n_lat   <= n_lat + 1;
        a_acc   <= '0;
        a_rises <= 0;
        a_llen  <= 0;
      end
    end
    a_pclk <= a_sclk;
    a_plat <= a_latch;
  end

  // DUT B monitor: a single transfer.
  logic        b_pclk = 1'b0, b_plat = 1'b0;
  logic [15:0] b_acc = '0;
  int          b_rises = 0, b_hi = 0, b_len = 0, b_start = 0, b_nlat = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (b_sclk) b_hi <= b_hi + 1;
      if (b_sclk && !b_pclk) begin
        b_acc   <= {b_acc[14:0], b_sdata};
        b_rises <= b_rises + 1;
      end
      if (b_latch) begin
        if (!b_plat) b_start <= cyc;
        b_len <= b_len + 1;
      end else if (b_plat) begin
        b_nlat <= b_nlat + 1;
      end
    end
    b_pclk <= b_sclk;
    b_plat <= b_latch;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present frame f on A and hold it until it is accepted. acc_cyc is the
  // cycle index of the accepting edge.
  task automatic send_a(input logic [15:0] f, output int acc_cyc);
    int t = 0;
    @(negedge clk);
    if_a.frame = f;
    if_a.frame_valid = 1'b1;
    while (!if_a.frame_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("send_a_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if_a.frame_valid = 1'b0;
  endtask

  task automatic wait_idle_a;
    int t = 0;
    @(negedge clk);
    while (a_busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("idle_a_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n1, n2, n3, base, r0, t;
    if_a.frame = '0; if_a.frame_valid = 1'b0;
    if_b.frame = '0; if_b.frame_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sclk",  32'(a_sclk),  32'd0);
    chk("rst_latch", 32'(a_latch), 32'd0);
    chk("rst_busy",  32'(a_busy),  32'd0);
    chk("rst_ready", 32'(if_a.frame_ready), 32'd1);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: a single frame
    send_a(16'hA5C3, n1);
    wait_idle_a();
    chk("t1_nlat",   32'(n_lat), 32'd1);
    chk("t1_word",   32'(lat_word[0]), 32'hA5C3);
    chk("t1_rises",  32'(lat_rises[0]), 32'd16);
    chk("t1_latlen", 32'(lat_len[0]), 32'd2);
    chk("t1_latst",  32'(lat_start[0] - n1), 32'd65);
    chk("t1_busy",   32'(a_busy), 32'd0);

    // 2: back-to-back frames with the pending buffer full
    base = n_lat;
    send_a(16'h8000, n1);
    repeat (13) @(posedge clk);
    send_a(16'hFFFF, n2);
    chk("t2_ffff_acc", 32'(n2 - n1), 32'd14);
    chk("t2_ready_lo", 32'(if_a.frame_ready), 32'd0);
    send_a(16'h0001, n3);
    chk("t2_0001_acc", 32'(n3 - n1), 32'd69);
    wait_idle_a();
    chk("t2_nlat",  32'(n_lat - base), 32'd3);
    chk("t2_w0",    32'(lat_word[base]), 32'h8000);
    chk("t2_w1",    32'(lat_word[base+1]), 32'hFFFF);
    chk("t2_w2",    32'(lat_word[base+2]), 32'h0001);
    chk("t2_st0",   32'(lat_start[base] - n1), 32'd65);
    chk("t2_gap01", 32'(lat_start[base+1] - lat_start[base]), 32'd67);
    chk("t2_gap12", 32'(lat_start[base+2] - lat_start[base+1]), 32'd67);

    // 3: asynchronous reset in bit 5 with a second frame pending
    base = n_lat;
    send_a(16'h1234, n1);
    send_a(16'hBEEF, n2);
    repeat (21) @(posedge clk);
    #1;
    chk("t3_pre_sclk",  32'(a_sclk), 32'd1);
    chk("t3_pre_ready", 32'(if_a.frame_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("t3_sclk",  32'(a_sclk),  32'd0);
    chk("t3_sdata", 32'(a_sdata), 32'd0);
    chk("t3_latch", 32'(a_latch), 32'd0);
    chk("t3_busy",  32'(a_busy),  32'd0);
    chk("t3_ready", 32'(if_a.frame_ready), 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("t3_nolatch",  32'(n_lat - base), 32'd0);
    chk("t3_busy_end", 32'(a_busy), 32'd0);
    chk("t3_ready_end", 32'(if_a.frame_ready), 32'd1);

    // 4: CLK_DIV=1 on DUT B
    @(negedge clk);
    if_b.frame = 16'h5555;
    if_b.frame_valid = 1'b1;
    @(posedge clk);
    #1;
    n1 = cyc;
    if_b.frame_valid = 1'b0;
    t = 0;
    while (b_nlat == 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("t4_timeout", 32'd1, 32'd0);
    @(negedge clk);
    chk("t4_word",  32'(b_acc), 32'h5555);
    chk("t4_rises", 32'(b_rises), 32'd16);
    chk("t4_hi",    32'(b_hi), 32'd16);
    chk("t4_latlen", 32'(b_len), 32'd1);
    chk("t4_latst", 32'(b_start - n1), 32'd33);
    chk("t4_busy",  32'(b_busy), 32'd0);

    // 5: a repeated frame (dropped only when the dedup feature is built in)
    base = n_lat;
    r0 = tot_rises;
    send_a(16'h00FF, n1);
    wait_idle_a();
    send_a(16'h00FF, n1);
    wait_idle_a();
    send_a(16'h0100, n1);
    wait_idle_a();
    chk("t5_nlat",  32'(n_lat - base), 32'(DEDUP_XFERS));
    chk("t5_rises", 32'(tot_rises - r0), 32'(16 * DEDUP_XFERS));
    chk("t5_first", 32'(lat_word[base]), 32'h00FF);
    chk("t5_last",  32'(lat_word[n_lat-1]), 32'h0100);
    chk("t5_busy",  32'(a_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
